// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory-port arbiter state and owner encodings,
// plus the default bus widths used by the core and its memory ports.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_WIDTH = 32;
  localparam int unsigned CPU_DATA_WIDTH = 32;

  // Arbiter transaction state. The encoding is fixed so that it can be
  // observed on a debug bus without translation.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_e;

  // Which CPU port currently owns the memory.
  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between the instruction-fetch
// port and the load/store port. One transaction may be outstanding; its
// response is routed back to the port that issued it. Data wins by default,
// but after STARVE_LIMIT consecutive lost arbitrations fetch is forced.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = CPU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = CPU_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  // instruction-fetch port
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  // load/store port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // memory macro port
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  // status
  output logic                    busy,
  output logic                    proto_err
);

  localparam int unsigned CNT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  arb_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic                 proto_err_q, proto_err_d;
  owner_e               sel;
  logic                 can_issue;

  // Data has priority unless fetch has lost CNT_MAX arbitrations in a row.
  // The forced-fetch case also requires if_req so that a saturated counter
  // can never block a lone data request.
  function automatic owner_e select_owner(input logic                 fetch_req,
                                          input logic                 data_req,
                                          input logic [CNT_WIDTH-1:0] cnt);
    if (!data_req || (fetch_req && (cnt == CNT_MAX))) begin
      return OWNER_FETCH;
    end
    return OWNER_DATA;
  endfunction

  // Request mux, grants and response routing (all combinational).
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    sel       = select_owner(if_req, d_req, starve_cnt_q);
    can_issue = nreset && (state_q == ARB_IDLE);
    mem_req   = can_issue && (if_req || d_req);
    mem_we    = 1'b0;
    mem_addr  = if_addr;
    mem_wdata = '0;
    mem_be    = '1;
    if (sel == OWNER_DATA) begin
      mem_we    = mem_req && d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
    if_gnt    = mem_req && mem_gnt && (sel == OWNER_FETCH);
    d_gnt     = mem_req && mem_gnt && (sel == OWNER_DATA);
    if_rvalid = mem_rvalid && (state_q == ARB_WAIT_I);
    d_rvalid  = mem_rvalid && (state_q == ARB_WAIT_D);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    busy      = (state_q != ARB_IDLE);
    proto_err = proto_err_q;
  end

  // Next state, starvation counter and sticky protocol-error flag.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    proto_err_d  = proto_err_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_rvalid) begin
          proto_err_d = 1'b1;
        end
        if (if_gnt) begin
          state_d      = ARB_WAIT_I;
          starve_cnt_d = '0;
        end else if (d_gnt) begin
          state_d = ARB_WAIT_D;
          if (if_req && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      ARB_WAIT_I, ARB_WAIT_D: begin
        if (mem_rvalid) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset drops any outstanding response.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. dut_a uses STARVE_LIMIT=4, dut_b uses
// STARVE_LIMIT=0; both share stimulus. Inputs change 1 ns after the rising
// edge and outputs are sampled 1 ns later, well clear of the next edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        a_mem_req, a_mem_we, a_busy, a_proto_err;
  logic [3:0]  a_mem_be;

  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_mem_req, b_mem_we, b_busy, b_proto_err;
  logic [3:0]  b_mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .nreset(nreset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(a_busy), .proto_err(a_proto_err)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(0)) dut_b (
    .clk(clk), .nreset(nreset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(b_busy), .proto_err(b_proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    nreset     = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    d_be       = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1 nreset  = 1'b0;
    next_cycle();
    next_cycle();

    // ---- reset state ----
    check("rst_busy",      32'(a_busy),      32'd0);
    check("rst_mem_req",   32'(a_mem_req),   32'd0);
    check("rst_if_rvalid", 32'(a_if_rvalid), 32'd0);
    check("rst_d_rvalid",  32'(a_d_rvalid),  32'd0);
    check("rst_proto_err", 32'(a_proto_err), 32'd0);
    nreset = 1'b1;

    // ---- fetch only ----
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h8;
    mem_gnt = 1'b1;
    settle();
    check("f_mem_req",  32'(a_mem_req),  32'd1);
    check("f_if_gnt",   32'(a_if_gnt),   32'd1);
    check("f_d_gnt",    32'(a_d_gnt),    32'd0);
    check("f_mem_addr", a_mem_addr,      32'h8);
    check("f_mem_be",   32'(a_mem_be),   32'hF);
    check("f_mem_we",   32'(a_mem_we),   32'd0);
    next_cycle();
    if_req     = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hE0822001;
    settle();
    check("f_busy",      32'(a_busy),      32'd1);
    check("f_wait_gnt",  32'(a_if_gnt),    32'd0);
    check("f_if_rvalid", 32'(a_if_rvalid), 32'd1);
    check("f_if_rdata",  a_if_rdata,       32'hE0822001);
    check("f_d_rvalid",  32'(a_d_rvalid),  32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    settle();
    check("f_idle",      32'(a_busy),      32'd0);
    check("f_proto_err", 32'(a_proto_err), 32'd0);

    // ---- contention, STARVE_LIMIT=4: D D D D I D ----
    if_req  = 1'b1;
    if_addr = 32'h100;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h40;
    d_be    = 4'hF;
    mem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic exp_fetch;
      exp_fetch = (i == 4);
      settle();
      check($sformatf("c%0d_if_gnt", i),   32'(a_if_gnt), 32'(exp_fetch));
      check($sformatf("c%0d_d_gnt", i),    32'(a_d_gnt),  32'(!exp_fetch));
      check($sformatf("c%0d_mem_addr", i), a_mem_addr,    exp_fetch ? 32'h100 : 32'h40);
      next_cycle();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1000 + 32'(i);
      settle();
      check($sformatf("c%0d_busy_gnt", i), 32'(a_if_gnt | a_d_gnt), 32'd0);
      check($sformatf("c%0d_if_rvalid", i), 32'(a_if_rvalid), 32'(exp_fetch));
      check($sformatf("c%0d_d_rvalid", i),  32'(a_d_rvalid),  32'(!exp_fetch));
      next_cycle();
      mem_rvalid = 1'b0;
    end
    check("c_cnt_restart", 32'(dut_a.starve_cnt_q), 32'd1);

    // ---- store ----
    if_req  = 1'b0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h10;
    d_wdata = 32'hDEADBEEF;
    d_be    = 4'b0011;
    mem_gnt = 1'b1;
    settle();
    check("s_d_gnt",     32'(a_d_gnt),   32'd1);
    check("s_mem_we",    32'(a_mem_we),  32'd1);
    check("s_mem_addr",  a_mem_addr,     32'h10);
    check("s_mem_wdata", a_mem_wdata,    32'hDEADBEEF);
    check("s_mem_be",    32'(a_mem_be),  32'h3);
    next_cycle();
    d_req      = 1'b0;
    d_we       = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0;
    settle();
    check("s_d_rvalid",  32'(a_d_rvalid),  32'd1);
    check("s_if_rvalid", 32'(a_if_rvalid), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    settle();
    check("s_cnt_keep", 32'(dut_a.starve_cnt_q), 32'd1);

    // ---- memory stall: 3 cycles without mem_gnt ----
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_addr  = 32'h20;
    d_be    = 4'hF;
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("st%0d_mem_req", i),  32'(a_mem_req),             32'd1);
      check($sformatf("st%0d_gnt", i),      32'(a_if_gnt | a_d_gnt),    32'd0);
      check($sformatf("st%0d_mem_addr", i), a_mem_addr,                 32'h20);
      check($sformatf("st%0d_busy", i),     32'(a_busy),                32'd0);
      check($sformatf("st%0d_cnt", i),      32'(dut_a.starve_cnt_q),    32'd1);
      next_cycle();
    end
    mem_gnt = 1'b1;
    settle();
    check("st_d_gnt",  32'(a_d_gnt),  32'd1);
    check("st_if_gnt", 32'(a_if_gnt), 32'd0);
    next_cycle();
    check("st_cnt_inc", 32'(dut_a.starve_cnt_q), 32'd2);
    if_req     = 1'b0;
    d_req      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    settle();
    check("st_d_rvalid", 32'(a_d_rvalid), 32'd1);
    check("st_d_rdata",  a_d_rdata,       32'h55AA55AA);
    next_cycle();
    mem_rvalid = 1'b0;

    // ---- reset mid-operation ----
    d_req  = 1'b1;
    d_addr = 32'h30;
    settle();
    check("r_d_gnt", 32'(a_d_gnt), 32'd1);
    next_cycle();
    check("r_busy_before", 32'(a_busy), 32'd1);
    nreset = 1'b0;
    settle();
    check("r_busy",      32'(a_busy),    32'd0);
    check("r_mem_req",   32'(a_mem_req), 32'd0);
    check("r_d_gnt_rst", 32'(a_d_gnt),   32'd0);
    check("r_cnt",       32'(dut_a.starve_cnt_q), 32'd0);
    next_cycle();
    nreset     = 1'b1;
    d_req      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    settle();
    check("r_late_d_rvalid",  32'(a_d_rvalid),  32'd0);
    check("r_late_if_rvalid", 32'(a_if_rvalid), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    settle();
    check("r_proto_err", 32'(a_proto_err), 32'd1);
    next_cycle();
    check("r_proto_sticky", 32'(a_proto_err), 32'd1);
    check("r_idle",         32'(a_busy),      32'd0);

    // ---- STARVE_LIMIT=0: fetch always wins ----
    if_req  = 1'b1;
    if_addr = 32'h300;
    d_req   = 1'b1;
    d_addr  = 32'h60;
    mem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("z%0d_if_gnt", i),   32'(b_if_gnt),  32'd1);
      check($sformatf("z%0d_d_gnt", i),    32'(b_d_gnt),   32'd0);
      check($sformatf("z%0d_mem_addr", i), b_mem_addr,     32'h300);
      check($sformatf("z%0d_mem_be", i),   32'(b_mem_be),  32'hF);
      next_cycle();
      mem_rvalid = 1'b1;
      settle();
      check($sformatf("z%0d_if_rvalid", i), 32'(b_if_rvalid), 32'd1);
      next_cycle();
      mem_rvalid = 1'b0;
    end
    if_req = 1'b0;
    d_req  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
